// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared widths, FSM encoding and request record for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int LANE_W = 1;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int RD_W   = 3;
    localparam int CNT_W  = 16;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              is_load;
        logic              is_store;
        logic              reg_we;
        logic [RD_W-1:0]   rd;
    } req_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_select2.sv
`default_nettype none
// ============================================================================
// Module  : rr_select2
// Brief   : Two-lane grant selection with round-robin pointer and ordering override.
// Revision: 1.0 - initial release
// ============================================================================
module rr_select2
    import mem_port_arbiter_pkg::*;
#(
    parameter int FAIR_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        valid_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic              store0_i,
    input  logic              store1_i,
    input  logic              accept_i,
    input  logic [LANE_W-1:0] grant_i,
    output logic [LANE_W-1:0] sel_o,
    output logic              ordered_o
);

    logic [LANE_W-1:0] ptr_q;
    logic [LANE_W-1:0] ptr_d;
    logic              conflict;

    // Same word touched by a store: keep program order, older lane wins.
    always_comb begin
        conflict  = (addr0_i == addr1_i) && (store0_i || store1_i);
        sel_o     = '0;
        ordered_o = 1'b0;
        if (valid_i == 2'b11) begin
            if (conflict) begin
                ordered_o = 1'b1;
            end else if (FAIR_MODE != 0) begin
                sel_o = ptr_q;
            end
        end else if (valid_i[1]) begin
            sel_o = LANE_W'(1);
        end
    end

    always_comb begin
        ptr_d = accept_i ? ~grant_i : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_select2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Arbitrates two issue lanes onto one memory port, returns load data.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int FAIR_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l0_valid,
    output logic              l0_ready,
    input  logic [ADDR_W-1:0] l0_addr,
    input  logic [DATA_W-1:0] l0_wdata,
    input  logic              l0_is_load,
    input  logic              l0_is_store,
    input  logic              l0_reg_we,
    input  logic [RD_W-1:0]   l0_rd,
    input  logic              l1_valid,
    output logic              l1_ready,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic [DATA_W-1:0] l1_wdata,
    input  logic              l1_is_load,
    input  logic              l1_is_store,
    input  logic              l1_reg_we,
    input  logic [RD_W-1:0]   l1_rd,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_is_load,
    output logic              mem_is_store,
    output logic              mem_reg_we,
    output logic [RD_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              l0_resp_valid,
    output logic [DATA_W-1:0] l0_resp_data,
    output logic [RD_W-1:0]   l0_resp_rd,
    output logic              l0_resp_we,
    output logic              l1_resp_valid,
    output logic [DATA_W-1:0] l1_resp_data,
    output logic [RD_W-1:0]   l1_resp_rd,
    output logic              l1_resp_we,
    output logic [CNT_W-1:0]  cnt_grant0,
    output logic [CNT_W-1:0]  cnt_grant1,
    output logic [CNT_W-1:0]  cnt_conflict
);

    state_t            state_q, state_d;
    req_t              hold_q;
    logic [LANE_W-1:0] hold_lane_q;
    logic              hold_ord_q;

    logic              resp_pend_q;
    logic [LANE_W-1:0] resp_lane_q;
    logic [RD_W-1:0]   resp_rd_q;
    logic              resp_we_q;

    logic [CNT_W-1:0]  cnt_g0_q, cnt_g0_d;
    logic [CNT_W-1:0]  cnt_g1_q, cnt_g1_d;
    logic [CNT_W-1:0]  cnt_cf_q, cnt_cf_d;

    req_t              req0, req1, grant_req;
    logic [LANE_W-1:0] idle_sel, grant_lane;
    logic              idle_ord, grant_ord;
    logic              accept;
    logic              resp0, resp1;

    always_comb begin
        req0 = '{addr: l0_addr, wdata: l0_wdata, is_load: l0_is_load,
                 is_store: l0_is_store, reg_we: l0_reg_we, rd: l0_rd};
        req1 = '{addr: l1_addr, wdata: l1_wdata, is_load: l1_is_load,
                 is_store: l1_is_store, reg_we: l1_reg_we, rd: l1_rd};
    end

    rr_select2 #(
        .FAIR_MODE (FAIR_MODE)
    ) u_rr_select2 (
        .clk       (clk),
        .rst       (rst),
        .valid_i   ({l1_valid, l0_valid}),
        .addr0_i   (l0_addr),
        .addr1_i   (l1_addr),
        .store0_i  (l0_is_store),
        .store1_i  (l1_is_store),
        .accept_i  (accept),
        .grant_i   (grant_lane),
        .sel_o     (idle_sel),
        .ordered_o (idle_ord)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_valid && !mem_ready) state_d = ST_HOLD;
            ST_HOLD: if (accept)                  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        if (state_q == ST_HOLD) begin
            grant_lane = hold_lane_q;
            grant_req  = hold_q;
            grant_ord  = hold_ord_q;
        end else begin
            grant_lane = idle_sel;
            grant_req  = (idle_sel == LANE_W'(0)) ? req0 : req1;
            grant_ord  = idle_ord;
        end
        mem_valid = !rst && (l0_valid || l1_valid || (state_q == ST_HOLD));
        accept    = mem_valid && mem_ready;
        l0_ready  = accept && (grant_lane == LANE_W'(0));
        l1_ready  = accept && (grant_lane == LANE_W'(1));
    end

    // A request flagged both load and store is a store to the memory unit.
    always_comb begin
        mem_addr     = grant_req.addr;
        mem_wdata    = grant_req.wdata;
        mem_is_load  = grant_req.is_load && !grant_req.is_store;
        mem_is_store = grant_req.is_store;
        mem_reg_we   = grant_req.reg_we;
        mem_rd       = grant_req.rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_lane_q <= '0;
            hold_ord_q  <= 1'b0;
            resp_pend_q <= 1'b0;
            resp_lane_q <= '0;
            resp_rd_q   <= '0;
            resp_we_q   <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && mem_valid && !mem_ready) begin
                hold_q      <= grant_req;
                hold_lane_q <= grant_lane;
                hold_ord_q  <= grant_ord;
            end
            resp_pend_q <= accept && !grant_req.is_store;
            if (accept) begin
                resp_lane_q <= grant_lane;
                resp_rd_q   <= grant_req.rd;
                resp_we_q   <= grant_req.reg_we;
            end
        end
    end

    // Write-back data comes straight from the memory unit in its valid cycle.
    always_comb begin
        resp0         = !rst && resp_pend_q && (resp_lane_q == LANE_W'(0));
        resp1         = !rst && resp_pend_q && (resp_lane_q == LANE_W'(1));
        l0_resp_valid = resp0;
        l0_resp_data  = resp0 ? mem_rdata : '0;
        l0_resp_rd    = resp0 ? resp_rd_q : '0;
        l0_resp_we    = resp0 && resp_we_q;
        l1_resp_valid = resp1;
        l1_resp_data  = resp1 ? mem_rdata : '0;
        l1_resp_rd    = resp1 ? resp_rd_q : '0;
        l1_resp_we    = resp1 && resp_we_q;
    end

    always_comb begin
        cnt_g0_d = (accept && (grant_lane == LANE_W'(0))) ? sat_inc(cnt_g0_q) : cnt_g0_q;
        cnt_g1_d = (accept && (grant_lane == LANE_W'(1))) ? sat_inc(cnt_g1_q) : cnt_g1_q;
        cnt_cf_d = (accept && grant_ord)                  ? sat_inc(cnt_cf_q) : cnt_cf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_g0_q <= '0;
            cnt_g1_q <= '0;
            cnt_cf_q <= '0;
        end else begin
            cnt_g0_q <= cnt_g0_d;
            cnt_g1_q <= cnt_g1_d;
            cnt_cf_q <= cnt_cf_d;
        end
    end

    assign cnt_grant0   = cnt_g0_q;
    assign cnt_grant1   = cnt_g1_q;
    assign cnt_conflict = cnt_cf_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed plus random stimulus against a behavioural arbiter model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v   [2];
    logic [4:0]  a   [2];
    logic [15:0] wd  [2];
    logic        ld  [2];
    logic        st  [2];
    logic        we  [2];
    logic [2:0]  rd  [2];
    logic        mrdy;
    logic [15:0] mrdata;

    logic        l0_ready, l1_ready, mem_valid;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_is_load, mem_is_store, mem_reg_we;
    logic [2:0]  mem_rd;
    logic        l0_resp_valid, l1_resp_valid, l0_resp_we, l1_resp_we;
    logic [15:0] l0_resp_data, l1_resp_data;
    logic [2:0]  l0_resp_rd, l1_resp_rd;
    logic [15:0] cnt_grant0, cnt_grant1, cnt_conflict;

    mem_port_arbiter #(.FAIR_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .l0_valid(v[0]), .l0_ready(l0_ready), .l0_addr(a[0]), .l0_wdata(wd[0]),
        .l0_is_load(ld[0]), .l0_is_store(st[0]), .l0_reg_we(we[0]), .l0_rd(rd[0]),
        .l1_valid(v[1]), .l1_ready(l1_ready), .l1_addr(a[1]), .l1_wdata(wd[1]),
        .l1_is_load(ld[1]), .l1_is_store(st[1]), .l1_reg_we(we[1]), .l1_rd(rd[1]),
        .mem_valid(mem_valid), .mem_ready(mrdy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store), .mem_reg_we(mem_reg_we),
        .mem_rd(mem_rd), .mem_rdata(mrdata),
        .l0_resp_valid(l0_resp_valid), .l0_resp_data(l0_resp_data),
        .l0_resp_rd(l0_resp_rd), .l0_resp_we(l0_resp_we),
        .l1_resp_valid(l1_resp_valid), .l1_resp_data(l1_resp_data),
        .l1_resp_rd(l1_resp_rd), .l1_resp_we(l1_resp_we),
        .cnt_grant0(cnt_grant0), .cnt_grant1(cnt_grant1), .cnt_conflict(cnt_conflict)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: the request being held, the pending write-back,
    // the fairness pointer and the counters as plain integers.
    bit          m_hold;
    int          m_hlane;
    logic [4:0]  m_ha;
    logic [15:0] m_hwd;
    logic        m_hld, m_hst, m_hwe, m_hord;
    logic [2:0]  m_hrd;
    int          m_ptr;
    bit          m_rp;
    int          m_rlane;
    logic [2:0]  m_rrd;
    logic        m_rwe;
    int          m_c0, m_c1, m_cc;
    bit          pend [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_hlane = 0; m_ptr = 0; m_rp = 0; m_rlane = 0;
        m_rrd = '0; m_rwe = 0; m_c0 = 0; m_c1 = 0; m_cc = 0;
        pend[0] = 0; pend[1] = 0;
    endtask

    function automatic int sat(input int c);
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    // Inputs are already driven; check mid-cycle, then advance the model.
    task automatic step();
        int g; logic ord, ev, acc, gst;
        logic [4:0] ea; logic [15:0] ewd; logic eld, ewe; logic [2:0] erd;
        logic r0, r1;
        #3;
        ord = 0;
        if (m_hold) begin
            g = m_hlane; ord = m_hord;
        end else if (v[0] && v[1]) begin
            if (a[0] == a[1] && (st[0] || st[1])) begin g = 0; ord = 1; end
            else g = m_ptr;
        end else begin
            g = v[1] ? 1 : 0;
        end
        if (m_hold) begin
            ea = m_ha; ewd = m_hwd; eld = m_hld; gst = m_hst; ewe = m_hwe; erd = m_hrd;
        end else begin
            ea = a[g]; ewd = wd[g]; eld = ld[g]; gst = st[g]; ewe = we[g]; erd = rd[g];
        end
        ev  = !rst && (v[0] || v[1] || m_hold);
        acc = ev && mrdy;
        chk("mem_valid", mem_valid, ev);
        chk("l0_ready", l0_ready, acc && g == 0);
        chk("l1_ready", l1_ready, acc && g == 1);
        if (ev) begin
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ewd);
            chk("mem_is_load", mem_is_load, eld && !gst);
            chk("mem_is_store", mem_is_store, gst);
            chk("mem_reg_we", mem_reg_we, ewe);
            chk("mem_rd", mem_rd, erd);
        end
        r0 = !rst && m_rp && m_rlane == 0;
        r1 = !rst && m_rp && m_rlane == 1;
        chk("l0_resp_valid", l0_resp_valid, r0);
        chk("l1_resp_valid", l1_resp_valid, r1);
        chk("l0_resp_data", l0_resp_data, r0 ? mrdata : 16'h0);
        chk("l1_resp_data", l1_resp_data, r1 ? mrdata : 16'h0);
        chk("l0_resp_rd", l0_resp_rd, r0 ? m_rrd : 3'h0);
        chk("l1_resp_rd", l1_resp_rd, r1 ? m_rrd : 3'h0);
        chk("l0_resp_we", l0_resp_we, r0 && m_rwe);
        chk("l1_resp_we", l1_resp_we, r1 && m_rwe);
        if (!rst) begin
            chk("cnt_grant0", cnt_grant0, m_c0);
            chk("cnt_grant1", cnt_grant1, m_c1);
            chk("cnt_conflict", cnt_conflict, m_cc);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int n = 0; n < 2; n++) pend[n] = v[n] && !(acc && g == n);
            if (acc) begin
                if (g == 0) m_c0 = sat(m_c0); else m_c1 = sat(m_c1);
                if (ord) m_cc = sat(m_cc);
                m_ptr = 1 - g;
                m_rp = !gst; m_rlane = g; m_rrd = erd; m_rwe = ewe;
                m_hold = 0;
            end else begin
                m_rp = 0;
                if (ev && !m_hold) begin
                    m_hold = 1; m_hlane = g; m_hord = ord;
                    m_ha = ea; m_hwd = ewd; m_hld = eld; m_hst = gst; m_hwe = ewe; m_hrd = erd;
                end
            end
        end
        #1;
    endtask

    task automatic set_lane(input int n, input logic vv, input logic [4:0] aa,
                            input logic [15:0] dd, input logic l, input logic s,
                            input logic w, input logic [2:0] r);
        v[n] = vv; a[n] = aa; wd[n] = dd; ld[n] = l; st[n] = s; we[n] = w; rd[n] = r;
    endtask

    initial begin
        model_reset();
        rst = 1; mrdy = 0; mrdata = '0;
        set_lane(0, 0, 0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        step();
        rst = 0;
        chk("reset_cnt_grant0", cnt_grant0, 0);
        chk("reset_cnt_conflict", cnt_conflict, 0);

        // Alternating fair grants between two non-conflicting loads.
        set_lane(0, 1, 5'd3, 16'h1111, 1, 0, 1, 3'd1);
        set_lane(1, 1, 5'd7, 16'h2222, 1, 0, 1, 3'd2);
        mrdy = 1;
        for (int i = 0; i < 4; i++) begin mrdata = 16'h5000 + 16'(i); step(); end
        set_lane(0, 0, 0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0, 0);
        mrdata = 16'h5A5A; step();

        // Pointer to lane 1, then a store/load clash on one address.
        set_lane(0, 1, 5'd2, 16'h0, 1, 0, 1, 3'd4); step();
        set_lane(0, 1, 5'd5, 16'h0, 1, 0, 1, 3'd5);
        set_lane(1, 1, 5'd5, 16'h7777, 0, 1, 0, 3'd0);
        step();
        set_lane(0, 0, 0, 0, 0, 0, 0, 0);
        chk("conflict_count", cnt_conflict, 1);
        step();
        set_lane(1, 0, 0, 0, 0, 0, 0, 0); step();

        // Stalled port: lane 0 held while lane 1 arrives.
        set_lane(0, 1, 5'd12, 16'h0, 1, 0, 1, 3'd6);
        mrdy = 0; step();
        set_lane(1, 1, 5'd13, 16'h0, 1, 0, 1, 3'd7); step(); step();
        mrdy = 1; step();
        set_lane(0, 0, 0, 0, 0, 0, 0, 0); step();
        set_lane(1, 0, 0, 0, 0, 0, 0, 0); step();

        // Store gets no response, following load to the same word does.
        set_lane(0, 1, 5'd9, 16'hABCD, 0, 1, 0, 3'd0); step();
        set_lane(0, 1, 5'd9, 16'h0, 1, 0, 1, 3'd3); step();
        set_lane(0, 0, 0, 0, 0, 0, 0, 0); mrdata = 16'hABCD; step();

        // Reset while a request is held.
        set_lane(0, 1, 5'd1, 16'h0, 1, 0, 1, 3'd2); mrdy = 0; step();
        mrdy = 1; rst = 1; step();
        rst = 0;
        chk("rst_hold_cnt0", cnt_grant0, 0);
        chk("rst_hold_resp0", l0_resp_valid, 0);
        set_lane(1, 1, 5'd8, 16'h0, 1, 0, 1, 3'd1); step(); step();
        set_lane(0, 0, 0, 0, 0, 0, 0, 0); set_lane(1, 0, 0, 0, 0, 0, 0, 0); step();

        // Random traffic; requesters hold their request until accepted.
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n])
                    set_lane(n, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 5)),
                             16'($urandom), 1'($urandom), 1'($urandom),
                             1'($urandom), 3'($urandom));
            end
            mrdy   = $urandom_range(0, 3) != 0;
            mrdata = 16'($urandom);
            rst    = $urandom_range(0, 99) == 0;
            step();
        end
        rst = 0;

        // Counter saturation.
        rst = 1; step(); rst = 0;
        set_lane(1, 0, 0, 0, 0, 0, 0, 0);
        set_lane(0, 1, 5'd1, 16'h0, 1, 0, 0, 3'd0);
        mrdy = 1;
        for (int i = 0; i < 65540; i++) step();
        chk("cnt_grant0_saturated", cnt_grant0, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
